// File: rtl/vga_overlay_pkg.sv
// vga_overlay_pkg
// Shared constants for the BCD text overlay: font character codes, glyph
// geometry and the font ROM address width, plus the nibble-to-character map.
package vga_overlay_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;
  localparam int ROM_AW  = 11;

  localparam logic [6:0] CHR_DIGIT_BASE = 7'h30;
  localparam logic [6:0] CHR_COLON      = 7'h3A;
  localparam logic [6:0] CHR_DASH       = 7'h2D;
  localparam logic [6:0] CHR_BLANK      = 7'h00;

  // A BCD nibble 0..9 becomes its ASCII digit; anything above 9 is not valid
  // BCD and is flagged visually with a dash.
  function automatic logic [6:0] nibble_to_char(input logic [3:0] nib);
    if (nib > 4'd9) return CHR_DASH;
    return CHR_DIGIT_BASE | {3'b000, nib};
  endfunction

endpackage

// File: rtl/overlay_blink_ctrl.sv
// overlay_blink_ctrl
// Frame-synchronous blink generator for the field under edit. Latches the
// edit row/field on each frame tick so the blinking field cannot change
// mid-frame, and toggles the blink phase every BLINK_FRAMES frame ticks.
// Ports:
//   clk_i, reset_i      pixel clock, synchronous active-high reset
//   frame_tick_i        one-cycle pulse at start of vertical blank
//   edit_row_i          line under edit (>= NUM_ROWS disables blinking)
//   edit_field_i        field 0..2 under edit, 3 = none
//   hide_o              1 while the latched edit field must render as background
//   edit_row_o          latched edit row
//   edit_field_o        latched edit field
module overlay_blink_ctrl #(
  parameter int NUM_ROWS     = 3,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_tick_i,
  input  logic [1:0] edit_row_i,
  input  logic [1:0] edit_field_i,
  output logic       hide_o,
  output logic [1:0] edit_row_o,
  output logic [1:0] edit_field_o
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;   // 0 = visible, 1 = hidden
  logic [1:0]       edit_row_q, edit_row_d;
  logic [1:0]       edit_field_q, edit_field_d;

  always_comb begin
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    edit_row_d   = edit_row_q;
    edit_field_d = edit_field_q;
    if (frame_tick_i) begin
      edit_row_d   = edit_row_i;
      edit_field_d = edit_field_i;
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      edit_row_q   <= 2'd0;
      edit_field_q <= 2'd3;
    end else begin
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      edit_row_q   <= edit_row_d;
      edit_field_q <= edit_field_d;
    end
  end

  assign hide_o       = phase_q && (int'(edit_row_q) < NUM_ROWS) && (edit_field_q != 2'd3);
  assign edit_row_o   = edit_row_q;
  assign edit_field_o = edit_field_q;

endmodule

// File: rtl/vga_bcd_overlay.sv
// vga_bcd_overlay
// Three-stage pipelined text overlay: draws NUM_ROWS lines of "DD:DD:DD"
// from a frame-latched BCD snapshot over the background RGB stream, using an
// external font ROM with one cycle of read latency.
// Ports:
//   clk_i, reset_i            pixel clock, synchronous active-high reset
//   pixel_x_i, pixel_y_i      current pixel position
//   video_on_i                active display area
//   hsync_i, vsync_i          syncs from the timing generator
//   frame_tick_i              start-of-vblank pulse, latches snapshot
//   rgb_i                     background pixel
//   bcd_data_i                line r at [24r+23:24r], field 0 in top byte
//   edit_row_i, edit_field_i  field under edit (field 3 = none)
//   rom_addr_o                {char[6:0], glyph_row[3:0]} to font ROM
//   rom_data_i                font ROM word, bit 7 = leftmost pixel
//   rgb_o                     composited pixel, 3 cycles after input
//   hsync_o, vsync_o          syncs delayed 3 cycles
module vga_bcd_overlay
  import vga_overlay_pkg::*;
#(
  parameter int         NUM_ROWS     = 3,
  parameter int         X0           = 192,
  parameter int         Y0           = 96,
  parameter int         ROW_PITCH    = 160,
  parameter int         SCALE_LOG2   = 1,
  parameter logic [7:0] FG_COLOUR    = 8'h07,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [9:0]               pixel_x_i,
  input  logic [9:0]               pixel_y_i,
  input  logic                     video_on_i,
  input  logic                     hsync_i,
  input  logic                     vsync_i,
  input  logic                     frame_tick_i,
  input  logic [7:0]               rgb_i,
  input  logic [NUM_ROWS*24-1:0]   bcd_data_i,
  input  logic [1:0]               edit_row_i,
  input  logic [1:0]               edit_field_i,
  output logic [ROM_AW-1:0]        rom_addr_o,
  input  logic [7:0]               rom_data_i,
  output logic [7:0]               rgb_o,
  output logic                     hsync_o,
  output logic                     vsync_o
);

  localparam int CW     = GLYPH_W << SCALE_LOG2;
  localparam int CH     = GLYPH_H << SCALE_LOG2;
  localparam int LINE_W = 8 * CW;

  // Frame snapshot of the BCD data; rendering never looks at bcd_data_i.
  logic [NUM_ROWS*24-1:0] bcd_q;

  logic       hide;
  logic [1:0] edit_row_l;
  logic [1:0] edit_field_l;

  overlay_blink_ctrl #(
    .NUM_ROWS     (NUM_ROWS),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .frame_tick_i (frame_tick_i),
    .edit_row_i   (edit_row_i),
    .edit_field_i (edit_field_i),
    .hide_o       (hide),
    .edit_row_o   (edit_row_l),
    .edit_field_o (edit_field_l)
  );

  // Stage 0: hit test, character selection and ROM address.
  logic              hit_d;
  logic [1:0]        row_d;
  logic [23:0]       line_bcd;
  int                dx, dy;
  logic [2:0]        char_idx;
  logic [2:0]        col_d;
  logic [3:0]        grow_d;
  logic [3:0]        nib;
  logic [1:0]        field_d;
  logic              is_digit;
  logic [6:0]        chr;
  logic              blank_d;
  logic [ROM_AW-1:0] addr_d;

  always_comb begin
    hit_d    = 1'b0;
    row_d    = 2'd0;
    line_bcd = '0;
    dx       = 0;
    dy       = 0;
    // Compare on full-width signed ints before subtracting so pixels left of
    // or above a line can never wrap around into a hit.
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!hit_d &&
          int'(pixel_x_i) >= X0 && int'(pixel_x_i) < X0 + LINE_W &&
          int'(pixel_y_i) >= Y0 + r * ROW_PITCH &&
          int'(pixel_y_i) <  Y0 + r * ROW_PITCH + CH) begin
        hit_d    = 1'b1;
        row_d    = 2'(r);
        line_bcd = bcd_q[24*r +: 24];
        dx       = int'(pixel_x_i) - X0;
        dy       = int'(pixel_y_i) - (Y0 + r * ROW_PITCH);
      end
    end

    char_idx = 3'(dx >> (3 + SCALE_LOG2));
    col_d    = 3'(dx >> SCALE_LOG2);
    grow_d   = 4'(dy >> SCALE_LOG2);

    nib      = 4'd0;
    field_d  = 2'd3;
    is_digit = 1'b1;
    case (char_idx)
      3'd0: begin nib = line_bcd[23:20]; field_d = 2'd0; end
      3'd1: begin nib = line_bcd[19:16]; field_d = 2'd0; end
      3'd3: begin nib = line_bcd[15:12]; field_d = 2'd1; end
      3'd4: begin nib = line_bcd[11:8];  field_d = 2'd1; end
      3'd6: begin nib = line_bcd[7:4];   field_d = 2'd2; end
      3'd7: begin nib = line_bcd[3:0];   field_d = 2'd2; end
      default: is_digit = 1'b0;          // indices 2 and 5 are colons
    endcase

    chr     = is_digit ? nibble_to_char(nib) : CHR_COLON;
    blank_d = hide && is_digit && (row_d == edit_row_l) && (field_d == edit_field_l);
    addr_d  = hit_d ? {chr, grow_d} : {CHR_BLANK, 4'd0};
  end

  // Stage 1 registers (also drive the ROM address).
  logic              hit1_q, blank1_q, video1_q, hs1_q, vs1_q;
  logic [2:0]        col1_q;
  logic [7:0]        rgb1_q;
  logic [ROM_AW-1:0] addr_q;
  // Stage 2 registers: side-band aligned with ROM data.
  logic              hit2_q, blank2_q, video2_q, hs2_q, vs2_q;
  logic [2:0]        col2_q;
  logic [7:0]        rgb2_q;
  // Stage 3 output registers.
  logic [7:0]        rgb_q, rgb_d;
  logic              hs3_q, vs3_q;
  logic              lit;

  always_comb begin
    lit   = rom_data_i[3'd7 - col2_q];
    rgb_d = rgb2_q;
    if (!video2_q)                       rgb_d = 8'h00;
    else if (hit2_q && !blank2_q && lit) rgb_d = FG_COLOUR;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bcd_q    <= '0;
      hit1_q   <= 1'b0;
      blank1_q <= 1'b0;
      video1_q <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      col1_q   <= 3'd0;
      rgb1_q   <= 8'h00;
      addr_q   <= '0;
      hit2_q   <= 1'b0;
      blank2_q <= 1'b0;
      video2_q <= 1'b0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      col2_q   <= 3'd0;
      rgb2_q   <= 8'h00;
      rgb_q    <= 8'h00;
      hs3_q    <= 1'b0;
      vs3_q    <= 1'b0;
    end else begin
      if (frame_tick_i) bcd_q <= bcd_data_i;
      hit1_q   <= hit_d;
      blank1_q <= blank_d;
      video1_q <= video_on_i;
      hs1_q    <= hsync_i;
      vs1_q    <= vsync_i;
      col1_q   <= col_d;
      rgb1_q   <= rgb_i;
      addr_q   <= addr_d;
      hit2_q   <= hit1_q;
      blank2_q <= blank1_q;
      video2_q <= video1_q;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      col2_q   <= col1_q;
      rgb2_q   <= rgb1_q;
      rgb_q    <= rgb_d;
      hs3_q    <= hs2_q;
      vs3_q    <= vs2_q;
    end
  end

  assign rom_addr_o = addr_q;
  assign rgb_o      = rgb_q;
  assign hsync_o    = hs3_q;
  assign vsync_o    = vs3_q;

endmodule

// File: tb/tb_vga_bcd_overlay.sv
// Directed bench for vga_bcd_overlay with a clocked font ROM model.
module tb_vga_bcd_overlay;

  localparam int NUM_ROWS = 3;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [9:0]             pixel_x, pixel_y;
  logic                   video_on, hsync, vsync, frame_tick;
  logic [7:0]             rgb_in;
  logic [NUM_ROWS*24-1:0] bcd_data;
  logic [1:0]             edit_row, edit_field;
  logic [10:0]            rom_addr;
  logic [7:0]             rom_data;
  logic [7:0]             rgb_out;
  logic                   hsync_out, vsync_out;

  // Font ROM model: one-cycle read latency, returns a bench-chosen word.
  logic [7:0] rom_word;
  always @(posedge clk) rom_data <= rom_word;

  vga_bcd_overlay #(
    .NUM_ROWS     (NUM_ROWS),
    .BLINK_FRAMES (2)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .pixel_x_i    (pixel_x),
    .pixel_y_i    (pixel_y),
    .video_on_i   (video_on),
    .hsync_i      (hsync),
    .vsync_i      (vsync),
    .frame_tick_i (frame_tick),
    .rgb_i        (rgb_in),
    .bcd_data_i   (bcd_data),
    .edit_row_i   (edit_row),
    .edit_field_i (edit_field),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .rgb_o        (rgb_out),
    .hsync_o      (hsync_out),
    .vsync_o      (vsync_out)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks: everything changes 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_px(input int x, input int y);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    step(1);  // ROM address for this pixel is now visible
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  // Field-1 digit (char 3) of line 0 and the neighbouring colon, rom_word=FF.
  task automatic blink_chk(input string tag, input logic [7:0] exp_digit);
    set_px(240, 96);
    step(2);
    chk({tag, "_digit"}, 16'(rgb_out), 16'(exp_digit));
    set_px(224, 96);
    step(2);
    chk({tag, "_colon"}, 16'(rgb_out), 16'h0007);
  endtask

  initial begin
    reset      = 1'b1;
    pixel_x    = 10'd0;
    pixel_y    = 10'd0;
    video_on   = 1'b0;
    hsync      = 1'b0;
    vsync      = 1'b0;
    frame_tick = 1'b0;
    rgb_in     = 8'h00;
    bcd_data   = '0;
    edit_row   = 2'd0;
    edit_field = 2'd3;
    rom_word   = 8'h00;
    step(2);
    reset = 1'b0;

    // Reset state after 3 idle cycles
    step(3);
    chk("rst_rgb",   16'(rgb_out),   16'h0000);
    chk("rst_hsync", 16'(hsync_out), 16'h0000);
    chk("rst_vsync", 16'(vsync_out), 16'h0000);
    chk("rst_addr",  16'(rom_addr),  16'h0000);

    // Pass-through latency: exactly 3 cycles
    video_on = 1'b1;
    rgb_in   = 8'h1A;
    hsync    = 1'b1;
    vsync    = 1'b1;
    step(2);
    chk("lat2_rgb",   16'(rgb_out),   16'h0000);
    chk("lat2_hsync", 16'(hsync_out), 16'h0000);
    step(1);
    chk("lat3_rgb",   16'(rgb_out),   16'h001A);
    chk("lat3_hsync", 16'(hsync_out), 16'h0001);
    chk("lat3_vsync", 16'(vsync_out), 16'h0001);
    hsync = 1'b0;
    vsync = 1'b0;

    // Snapshot and character mapping
    bcd_data = {24'hA9_00_00, 24'h78_90_12, 24'h12_34_56};
    tick();
    rom_word = 8'h80;

    set_px(192, 96);
    chk("l0_c0_addr", 16'(rom_addr), 16'h0310);
    step(2);
    chk("l0_c0_rgb", 16'(rgb_out), 16'h0007);

    set_px(194, 96);
    chk("l0_col1_addr", 16'(rom_addr), 16'h0310);
    step(2);
    chk("l0_col1_rgb", 16'(rgb_out), 16'h001A);

    set_px(224, 100);
    chk("colon_addr", 16'(rom_addr), 16'h03A2);
    step(2);
    chk("colon_rgb", 16'(rgb_out), 16'h0007);

    set_px(192, 256);
    chk("l1_c0_addr", 16'(rom_addr), 16'h0370);
    set_px(304, 287);
    chk("l1_c7_corner_addr", 16'(rom_addr), 16'h032F);
    set_px(192, 416);
    chk("l2_dash_addr", 16'(rom_addr), 16'h02D0);
    set_px(208, 416);
    chk("l2_nine_addr", 16'(rom_addr), 16'h0390);

    // Boundaries just outside line 0
    set_px(320, 96);
    chk("right_edge_addr", 16'(rom_addr), 16'h0000);
    step(2);
    chk("right_edge_rgb", 16'(rgb_out), 16'h001A);
    set_px(191, 96);
    chk("left_edge_addr", 16'(rom_addr), 16'h0000);
    set_px(192, 128);
    chk("bottom_edge_addr", 16'(rom_addr), 16'h0000);
    set_px(192, 95);
    chk("top_edge_addr", 16'(rom_addr), 16'h0000);

    // Blanking outside the active area forces black
    video_on = 1'b0;
    set_px(192, 96);
    step(2);
    chk("video_off_rgb", 16'(rgb_out), 16'h0000);
    video_on = 1'b1;

    // Mid-frame data change is invisible until the next tick
    bcd_data[23:0] = 24'h99_99_99;
    set_px(192, 96);
    chk("midframe_addr", 16'(rom_addr), 16'h0310);
    tick();
    set_px(192, 96);
    chk("after_tick_addr", 16'(rom_addr), 16'h0390);

    // Reset wins over a coincident frame tick
    reset      = 1'b1;
    frame_tick = 1'b1;
    step(1);
    reset      = 1'b0;
    frame_tick = 1'b0;
    set_px(192, 96);
    chk("rst_tick_addr", 16'(rom_addr), 16'h0300);

    // Blink, BLINK_FRAMES = 2, counter cleared by the reset above
    rom_word   = 8'hFF;
    edit_row   = 2'd0;
    edit_field = 2'd1;
    tick();                       // frame 1
    blink_chk("f1", 8'h07);
    tick();                       // frame 2
    blink_chk("f2", 8'h1A);
    set_px(192, 96);
    step(2);
    chk("f2_field0", 16'(rgb_out), 16'h0007);
    tick();                       // frame 3
    blink_chk("f3", 8'h1A);
    tick();                       // frame 4
    blink_chk("f4", 8'h07);
    tick();                       // frame 5
    blink_chk("f5", 8'h07);
    tick();                       // frame 6
    blink_chk("f6", 8'h1A);
    edit_field = 2'd3;
    tick();                       // frame 7, hidden phase, no field
    blink_chk("f7_none", 8'h07);
    edit_row   = 2'd3;
    edit_field = 2'd1;
    tick();                       // frame 8 visible
    tick();                       // frame 9 visible
    tick();                       // frame 10 hidden, but row out of range
    blink_chk("f10_row_oob", 8'h07);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
